// File: rtl/vs_msg_pkg.sv
// vs_msg_pkg: game message field map, opcodes and dispatcher FSM encoding
// shared with the upstream message producer.
package vs_msg_pkg;
    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_REVEAL   = 4'd1;
    localparam logic [3:0] OP_FLAG     = 4'd2;
    localparam logic [3:0] OP_UNFLAG   = 4'd3;
    localparam logic [3:0] OP_NEW_GAME = 4'd4;
    localparam int OP_HI  = 23;
    localparam int OP_LO  = 20;
    localparam int ROW_HI = 19;
    localparam int ROW_LO = 12;
    localparam int COL_HI = 11;
    localparam int COL_LO = 4;
    localparam int ARG_HI = 3;
    localparam int ARG_LO = 0;
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_DECODE, S_ISSUE, S_BACKOFF
    } state_t;
endpackage

// File: rtl/vs_msg_decode.sv
// vs_msg_decode: splits a game message into command fields and classifies it
// as legal / no-op; NEW_GAME ignores the board coordinates.
module vs_msg_decode
    import vs_msg_pkg::*;
#(
    parameter int MSG_W = 24,
    parameter int ROWS  = 16,
    parameter int COLS  = 16
) (
    input  logic [MSG_W-1:0] msg,
    output logic [2:0]       op,
    output logic [7:0]       row,
    output logic [7:0]       col,
    output logic [3:0]       arg,
    output logic             legal,
    output logic             is_nop
);
    logic [3:0] opc;
    logic [7:0] r;
    logic [7:0] c;
    logic       in_range;
    logic       is_new;
    assign opc      = msg[OP_HI:OP_LO];
    assign r        = msg[ROW_HI:ROW_LO];
    assign c        = msg[COL_HI:COL_LO];
    assign arg      = msg[ARG_HI:ARG_LO];
    // 9-bit compare so a 256-wide board accepts every 8-bit index
    assign in_range = ({1'b0, r} < 9'(ROWS)) && ({1'b0, c} < 9'(COLS));
    assign is_new   = opc == OP_NEW_GAME;
    assign is_nop   = opc == OP_NOP;
    assign legal    = is_new || (opc >= OP_REVEAL && opc <= OP_UNFLAG && in_range);
    assign op       = opc[2:0];
    assign row      = is_new ? 8'd0 : r;
    assign col      = is_new ? 8'd0 : c;
endmodule

// File: rtl/queue_cmd_dispatcher.sv
// queue_cmd_dispatcher: polls the message queue, latches one message at a time,
// validates it and issues it over a valid/ready command port; counts dropped messages.
module queue_cmd_dispatcher
    import vs_msg_pkg::*;
#(
    parameter int MSG_W    = 24,
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int POLL_GAP = 4,
    parameter int SETTLE   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic             q_read_req,
    input  logic             q_read_valid,
    input  logic [MSG_W-1:0] q_read_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [2:0]       cmd_op,
    output logic [7:0]       cmd_row,
    output logic [7:0]       cmd_col,
    output logic [3:0]       cmd_arg,
    output logic             busy,
    output logic [7:0]       err_count
);
    state_t           state;
    logic [7:0]       cnt;
    logic [MSG_W-1:0] msg;
    logic [2:0]       d_op;
    logic [7:0]       d_row;
    logic [7:0]       d_col;
    logic [3:0]       d_arg;
    logic             legal;
    logic             is_nop;

    vs_msg_decode #(.MSG_W(MSG_W), .ROWS(ROWS), .COLS(COLS)) u_decode (
        .msg(msg), .op(d_op), .row(d_row), .col(d_col), .arg(d_arg),
        .legal(legal), .is_nop(is_nop)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            msg        <= '0;
            q_read_req <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_op     <= 3'd0;
            cmd_row    <= 8'd0;
            cmd_col    <= 8'd0;
            cmd_arg    <= 4'd0;
            busy       <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            q_read_req <= 1'b0;
            case (state)
                S_IDLE: if (enable) begin
                    state      <= S_REQ;
                    q_read_req <= 1'b1;
                    busy       <= 1'b1;
                end
                S_REQ: begin
                    state <= S_WAIT;
                    cnt   <= 8'd0;
                end
                S_WAIT: if (cnt == 8'(SETTLE - 1)) begin
                    if (q_read_valid) begin
                        msg   <= q_read_data;
                        state <= S_DECODE;
                    end else begin
                        state <= S_BACKOFF;
                        cnt   <= 8'd0;
                    end
                end else cnt <= cnt + 8'd1;
                S_DECODE: if (legal) begin
                    state     <= S_ISSUE;
                    cmd_valid <= 1'b1;
                    cmd_op    <= d_op;
                    cmd_row   <= d_row;
                    cmd_col   <= d_col;
                    cmd_arg   <= d_arg;
                end else begin
                    if (!is_nop && err_count != 8'hff) err_count <= err_count + 8'd1;
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_ISSUE: if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                end
                S_BACKOFF: if (cnt == 8'(POLL_GAP - 1)) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end else cnt <= cnt + 8'd1;
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
